qsqrt: RTL and testbench
========================

# qsqrt

Iterative fixed-point square-root unit for the QR-decomposition datapath. Takes the sign-magnitude sum-of-squares of a column (same Q-format as the divider) and produces its root, the column norm. That norm is the divisor operand for the downstream fixed-point divider. Digit-by-digit restoring algorithm: one result bit per clock, constant latency, start/complete handshake matching the divider's.

## Interface
- `Q`, 8, fractional bits of input and output. Legal range: 1 ≤ Q ≤ N-3.
- `N`, 16, total word width. Bit N-1 is the sign; bits N-2:0 are the magnitude.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  reset, asynchronous, active-high; clears all state.
- `i_radicand`  in  N  sign-magnitude Q-format operand; sampled only when a start is accepted.
- `i_start`  in  1  start request; level-sampled on the rising edge.
- `o_root`  out  N  sign-magnitude Q-format result; sign bit always 0; held until the next completion.
- `o_busy`  out  1  high while in CALC.
- `o_complete`  out  1  one-cycle pulse; `o_root` and `o_invalid` are valid and updated in that cycle.
- `o_invalid`  out  1  radicand was negative (sign=1, magnitude≠0); held with `o_root`.

## Operation
- Internal widths:
  - Extended radicand `X = magnitude << Q`, width N-1+Q, zero-padded at the top to even width RW.
  - ITER = RW/2. For N=16, Q=8: RW=24, ITER=12.
  - Partial root: ITER bits. Remainder: ITER+2 bits.
- FSM states:
  - IDLE: waits for `i_start`.
  - CALC: one iteration per clock for ITER clocks.
  - DONE: asserts `o_complete` for one cycle.
- Transitions:
  - IDLE→CALC on `i_start`.
  - CALC→DONE after the ITER-th iteration.
  - DONE→CALC on `i_start`; DONE→IDLE otherwise.
- Start acceptance:
  - Accepted only in IDLE or DONE.
  - `i_start` while in CALC is ignored: no queuing, no effect on the current operation.
- Accept action:
  - Latch `X`, clear partial root and remainder.
  - Latch the negative flag: sign=1 and magnitude≠0.
- Iteration action:
  - Shift the next two radicand bits into the remainder.
  - Trial value = (root<<2)|1.
  - If remainder ≥ trial: subtract the trial value and shift 1 into root; otherwise shift 0 into root.
- Completion:
  - `o_root[N-2:0]` = final root, zero-extended.
  - `o_root[N-1]` = 0.
  - Negative input forces `o_root` = 0 and `o_invalid` = 1. The iteration count is unchanged.
- Negative zero (0x8000 for N=16): root 0, `o_invalid` = 0.
- Result width: root < 2^ITER ≤ 2^(N-1), so there is no overflow path.

## Timing
- Reset values:
  - `o_root` = 0, `o_busy` = 0, `o_complete` = 0, `o_invalid` = 0.
  - FSM in IDLE; working registers cleared.
- Reset mid-operation: immediate abort, all outputs go to their reset values, no `o_complete` pulse.
- Latency: start accepted on edge k → `o_busy` high from k until edge k+ITER → `o_complete` high for exactly the cycle between edges k+ITER and k+ITER+1.
- Back-to-back operation:
  - `i_start` held high during the `o_complete` cycle is accepted on the next edge.
  - Throughput is one result per ITER+1 cycles.
- `i_radicand` may change freely after the accept edge.
- `o_root` and `o_invalid` change only on the edge that enters DONE (or on reset).

## Configuration
- `QSQRT_ROUND_EN` defined:
  - Round to nearest: on the final iteration, if the final remainder > final root, the result is root+1.
  - Evaluated within the same clock, so latency is unchanged.
- `QSQRT_ROUND_EN` undefined: result is truncated (floor of the exact root in Q-format).

## Test plan
- 0x0400 (4.0) → 0x0200, `o_invalid`=0, `o_complete` exactly 12 cycles after the accept edge; 0x0200 (2.0) → 0x016A; 0x0080 (0.5) → 0x00B5.
- 0x0005 → 0x0023 with `QSQRT_ROUND_EN` undefined; 0x0024 with it defined. Same latency in both builds.
- Boundaries: 0x0000 → 0x0000; 0x8000 → 0x0000 with `o_invalid`=0; 0x7FFF → 0x0B50; 0x8400 → 0x0000 with `o_invalid`=1.
- Handshake: `i_start` pulsed at cycles 3 and 6 of an active operation → ignored, first result unchanged. `i_start` held high continuously → completions every 13 cycles.
- Assert `i_reset` at iteration 5 → all outputs 0 asynchronously, no `o_complete`. After release, a new start of 0x0400 returns 0x0200.

Source files
------------

// File: rtl/qsqrt.sv
// -----------------------------------------------------------------------------
// qsqrt -- iterative fixed-point square root (digit-by-digit, restoring)
//
// Computes the column norm for the QR-decomposition datapath from the
// sign-magnitude sum-of-squares. The result is the divisor operand for the
// downstream fixed-point divider, so the start/complete handshake mirrors the
// divider's. One result bit is produced per clock, so latency is constant.
//
// Parameters
//   Q  fractional bits of input and output (1 <= Q <= N-3)
//   N  total word width; bit N-1 is the sign, bits N-2:0 the magnitude
//
// Ports
//   i_clk       clock, rising edge
//   i_reset     asynchronous, active-high reset; clears all state
//   i_radicand  sign-magnitude Q-format operand, sampled when a start is accepted
//   i_start     start request, level-sampled; ignored while busy
//   o_root      sign-magnitude Q-format root (sign always 0), held until the
//               next completion
//   o_busy      high while iterating
//   o_complete  one-cycle pulse; o_root / o_invalid are updated in that cycle
//   o_invalid   radicand was negative (sign=1, magnitude!=0); held with o_root
//
// Configuration
//   QSQRT_ROUND_EN  when defined, the result is rounded to nearest
//                   (root+1 if final remainder > final root); otherwise the
//                   result is truncated. Latency is identical in both builds.
// -----------------------------------------------------------------------------
module qsqrt #(
  parameter int Q = 8,
  parameter int N = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [N-1:0] i_radicand,
  input  logic         i_start,
  output logic [N-1:0] o_root,
  output logic         o_busy,
  output logic         o_complete,
  output logic         o_invalid
);

  // Magnitude width, extended radicand width, and its even-padded width.
  localparam int MW   = N - 1;
  localparam int XW   = MW + Q;
  localparam int RW   = XW + (XW % 2);
  localparam int ITER = RW / 2;
  // Remainder width: ITER+2 bits covers the largest shifted remainder
  // (at most 8*root+3 with root < 2^(ITER-1) on the final step).
  localparam int RMW  = ITER + 2;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t          state;
  logic [RW-1:0]   x;      // remaining radicand bits, consumed two per clock from the top
  logic [ITER-1:0] root;   // partial root
  logic [RMW-1:0]  rem;    // partial remainder
  logic [CW-1:0]   cnt;    // iterations completed in this operation
  logic            neg;    // operand was a true negative (not negative zero)

  // Operand decode, used only on the accept edge.
  logic [MW-1:0]   mag;
  logic [RW-1:0]   x_init;
  logic            start_neg;

  // One restoring iteration.
  logic [RMW-1:0]  rem_shift;
  logic [RMW-1:0]  trial;
  logic            fits;
  logic [RMW-1:0]  rem_next;
  logic [ITER-1:0] root_next;

  // Final result formation.
  logic            last_iter;
  logic            round_up;
  logic [MW-1:0]   result;

  assign mag       = i_radicand[N-2:0];
  assign x_init    = RW'(mag) << Q;
  // Negative zero (sign set, magnitude 0) is a legal input whose root is 0.
  assign start_neg = i_radicand[N-1] & (|mag);
  assign last_iter = (cnt == CW'(ITER - 1));

  // NOTE: every always_comb output gets a default before any condition, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    rem_shift = '0;
    trial     = '0;
    fits      = 1'b0;
    rem_next  = '0;
    root_next = '0;
    round_up  = 1'b0;
    result    = '0;

    // Bring the next two radicand bits into the remainder. The top two bits of
    // rem are always zero here, so the truncating cast loses nothing.
    rem_shift = RMW'({rem, x[RW-1 -: 2]});
    trial     = {root, 2'b01};
    fits      = (rem_shift >= trial);
    rem_next  = fits ? (rem_shift - trial) : rem_shift;
    root_next = {root[ITER-2:0], fits};

`ifdef QSQRT_ROUND_EN
    // x - r^2 > r  <=>  x > r^2 + r  <=>  sqrt(x) > r + 1/2 (integers).
    round_up  = (rem_next > RMW'(root_next));
`else
    round_up  = 1'b0;
`endif

    // root < 2^ITER <= 2^(N-1), so adding the rounding bit cannot overflow.
    result    = MW'(root_next) + MW'(round_up);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values and ordering inside the block is
  // irrelevant.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= S_IDLE;
      x          <= '0;
      root       <= '0;
      rem        <= '0;
      cnt        <= '0;
      neg        <= 1'b0;
      o_root     <= '0;
      o_busy     <= 1'b0;
      o_complete <= 1'b0;
      o_invalid  <= 1'b0;
    end else begin
      o_complete <= 1'b0;

      case (state)
        // A start is accepted from IDLE and from DONE, which gives back-to-back
        // operation at one result per ITER+1 cycles.
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state  <= S_CALC;
            o_busy <= 1'b1;
            x      <= x_init;
            root   <= '0;
            rem    <= '0;
            cnt    <= '0;
            neg    <= start_neg;
          end else begin
            state  <= S_IDLE;
          end
        end

        // i_start is not looked at here: requests during an operation are dropped.
        S_CALC: begin
          x    <= x << 2;
          root <= root_next;
          rem  <= rem_next;
          cnt  <= cnt + CW'(1);
          if (last_iter) begin
            state      <= S_DONE;
            o_busy     <= 1'b0;
            o_complete <= 1'b1;
            // A negative operand still runs the full iteration count so latency
            // stays constant; only the published result is forced.
            o_root     <= neg ? '0 : {1'b0, result};
            o_invalid  <= neg;
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qsqrt.sv
// -----------------------------------------------------------------------------
// tb_qsqrt -- self-checking bench for qsqrt (N=16, Q=8, ITER=12)
//
// Expected results are pushed to a scoreboard queue when a start is driven and
// popped when o_complete is seen. Each entry also carries the cycle in which
// o_complete must appear, so latency is checked on every operation.
// -----------------------------------------------------------------------------
module tb_qsqrt;

  localparam int N    = 16;
  localparam int Q    = 8;
  localparam int ITER = 12;

  typedef struct {
    logic [N-1:0] root;
    logic         inv;
    int           cyc;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_reset;
  logic [N-1:0] i_radicand;
  logic         i_start;
  logic [N-1:0] o_root;
  logic         o_busy;
  logic         o_complete;
  logic         o_invalid;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [N-1:0] last_root = '0;

  qsqrt #(.Q(Q), .N(N)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_radicand (i_radicand),
    .i_start    (i_start),
    .o_root     (o_root),
    .o_busy     (o_busy),
    .o_complete (o_complete),
    .o_invalid  (o_invalid)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference root: largest r with r*r <= X by bit-wise search, then optional
  // round to nearest using the exact remainder.
  function automatic logic [N-1:0] model_root(input logic [N-1:0] rad);
    longint x;
    longint r;
    longint t;
    x = longint'(rad[N-2:0]) << Q;
    r = 0;
    for (int b = ITER; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= x) r = t;
    end
`ifdef QSQRT_ROUND_EN
    if (x - r * r > r) r = r + 1;
`endif
    if (rad[N-1] && rad[N-2:0] != '0) r = 0;
    return N'(r);
  endfunction

  function automatic logic model_inv(input logic [N-1:0] rad);
    return rad[N-1] && (rad[N-2:0] != '0);
  endfunction

  // Scoreboard consumer: sample away from the active edge.
  always @(negedge i_clk) begin
    if (!i_reset && o_complete) begin
      if (sb.size() == 0) begin
        check("unexpected_complete", 32'(o_complete), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("root", 32'(o_root), 32'(e.root));
        check("invalid", 32'(o_invalid), 32'(e.inv));
        check("latency", 32'(cyc), 32'(e.cyc));
        last_root = e.root;
      end
    end
  end

  // Wait (bounded) until the DUT can accept, then drive one start and push
  // the expectation. Returns just after the accept edge.
  task automatic start_op(input logic [N-1:0] rad, input logic [N-1:0] exp_root,
                          input logic exp_inv);
    int k;
    k = 0;
    @(negedge i_clk);
    while (o_busy && k < 100) begin
      @(negedge i_clk);
      k++;
    end
    if (o_busy) check("accept_timeout", 32'(o_busy), 32'd0);
    i_radicand = rad;
    i_start    = 1'b1;
    sb.push_back('{root: exp_root, inv: exp_inv, cyc: cyc + ITER + 1});
    @(posedge i_clk);
    #1;
    i_start    = 1'b0;
    i_radicand = N'($urandom);   // operand must already be latched
    check("busy_after_accept", 32'(o_busy), 32'd1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge i_clk);
      k++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_op(input logic [N-1:0] rad, input logic [N-1:0] exp_root,
                        input logic exp_inv);
    start_op(rad, exp_root, exp_inv);
    wait_done();
  endtask

  logic [N-1:0] rnd;
  int           c0;

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_radicand = '0;
    #1;
    check("rst_root", 32'(o_root), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_complete", 32'(o_complete), 32'd0);
    check("rst_invalid", 32'(o_invalid), 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;

    // Directed values and boundaries.
    run_op(16'h0400, 16'h0200, 1'b0);
    repeat (3) @(negedge i_clk);
    check("hold_root", 32'(o_root), 32'(last_root));
    run_op(16'h0200, 16'h016A, 1'b0);
    run_op(16'h0080, 16'h00B5, 1'b0);
`ifdef QSQRT_ROUND_EN
    run_op(16'h0005, 16'h0024, 1'b0);
`else
    run_op(16'h0005, 16'h0023, 1'b0);
`endif
    run_op(16'h0000, 16'h0000, 1'b0);
    run_op(16'h8000, 16'h0000, 1'b0);
    run_op(16'h7FFF, 16'h0B50, 1'b0);

    // Starts during an active operation are dropped.
    start_op(16'h0200, 16'h016A, 1'b0);
    repeat (2) @(posedge i_clk);
    #1 i_start = 1'b1; i_radicand = 16'h0005;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_start = 1'b1; i_radicand = 16'h7FFF;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done();
    repeat (20) @(posedge i_clk);

    // Start held high: accepts on the edge after each completion, with the
    // operand changed right after each accept edge.
    @(negedge i_clk);
    c0 = cyc;
    i_start    = 1'b1;
    i_radicand = 16'h0400;
    sb.push_back('{root: 16'h0200, inv: 1'b0, cyc: c0 + 13});
    sb.push_back('{root: 16'h016A, inv: 1'b0, cyc: c0 + 26});
    sb.push_back('{root: 16'h00B5, inv: 1'b0, cyc: c0 + 39});
    @(posedge i_clk);
    #1 i_radicand = 16'h0200;
    repeat (13) @(posedge i_clk);
    #1 i_radicand = 16'h0080;
    repeat (13) @(posedge i_clk);
    #1 i_start = 1'b0;
    wait_done();

    // Random operands against the reference model.
    for (int i = 0; i < 16; i++) begin
      rnd = N'($urandom_range(0, 65535));
      run_op(rnd, model_root(rnd), model_inv(rnd));
    end

    // True negative; leaves o_invalid=1 and o_root=0 before the reset test.
    run_op(16'h0400, 16'h0200, 1'b0);
    run_op(16'h8400, 16'h0000, 1'b1);

    // Reset at iteration 5: asynchronous clear, no completion afterwards.
    @(negedge i_clk);
    i_radicand = 16'h7FFF;
    i_start    = 1'b1;
    @(posedge i_clk);
    #1 i_start = 1'b0;
    check("busy_before_reset", 32'(o_busy), 32'd1);
    repeat (5) @(posedge i_clk);
    #2 i_reset = 1'b1;
    #1;
    check("arst_root", 32'(o_root), 32'd0);
    check("arst_busy", 32'(o_busy), 32'd0);
    check("arst_complete", 32'(o_complete), 32'd0);
    check("arst_invalid", 32'(o_invalid), 32'd0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (20) @(posedge i_clk);
    run_op(16'h0400, 16'h0200, 1'b0);

    repeat (5) @(posedge i_clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
